tdm_frame_tx: RTL and testbench
===============================

// Module: tdm_frame_tx
// PURPOSE
//  Transmit end of the f0/c4 TDM link. Generates the c4 bit clock and the active-low f0 frame pulse
//  from clk50, and serialises a double-buffered table of channel bytes onto data_to_dt.
//  Drives the far-end receiver that samples data_to_dt against c4/f0.
//  Host side writes a shadow bank and commits it; banks swap only on a frame boundary.
// PARAMETERS
//  C4_HALF   6   clk50 cycles per c4 half-period (c4 period = 2*C4_HALF clk50 cycles); min 2
//  CHANNELS  32  8-bit channels per frame; BITS = 8*CHANNELS; c4 periods per frame P = 2*BITS
//  CH_W      5   channel address width, 2**CH_W >= CHANNELS
// PORTS
//  clk50        in   1     system clock, all logic on posedge
//  reset_n      in   1     asynchronous active-low reset
//  enable       in   1     1 = run framing, 0 = idle line
//  wr_en        in   1     write wr_data into shadow bank at wr_addr
//  wr_addr      in   CH_W  channel index; addresses >= CHANNELS are ignored
//  wr_data      in   8     channel byte
//  commit       in   1     1-cycle pulse: request shadow/active swap at next frame boundary
//  c4           out  1     bit clock, high in 1st half of each c4 period
//  f0           out  1     frame pulse, active low
//  data_to_dt   out  1     serial data, MSB first, channel 0 first
//  frame_start  out  1     1-cycle pulse on entry to c4 period 0
//  swap_done    out  1     1-cycle pulse when a pending commit was applied
//  stale        out  1     1-cycle pulse at frame start with no commit pending (frame repeats data)
// BEHAVIOUR
//  - Reset: c4=0, f0=1, data_to_dt=1, all pulses 0, both banks all 8'hFF, active=bank0, pending=0.
//  - Counters: div 0..C4_HALF-1, half-phase ph (0=high,1=low), pcnt 0..P-1 (c4 period index).
//  - enable=0: div/ph/pcnt held at 0, c4=0, f0=1, data_to_dt=1; writes/commit still accepted.
//  - Start: enable first seen high in cycle N -> at edge N+1: c4=1, pcnt=0, frame_start=1,
//    data_to_dt = bit7 of channel 0 from (post-swap) active bank.
//  - Running: div increments each clk50; at div==C4_HALF-1, div<=0 and:
//    ph==0 -> c4<=0, ph<=1;
//    ph==1 -> c4<=1, ph<=0, pcnt<=pcnt+1 (P-1 wraps to 0).
//  - Data bit k (0..BITS-1) is driven for periods 2k and 2k+1; it updates on the edge entering even
//    period 2k and is stable across two full c4 periods. Bit k = active[k/8][7-(k%8)].
//  - f0 <= 0 on the edge entering pcnt==P-1; f0 <= 1 on the edge entering pcnt==0.
//  - Frame boundary (edge entering pcnt==0, including start): frame_start=1; if pending ->
//    active toggles, pending<=0, swap_done=1; else stale=1. Channel 0 byte is taken from the
//    post-swap active bank in that same edge.
//  - commit sets pending; commit in the boundary cycle counts for the NEXT boundary.
//    Repeated commits before a boundary = one swap.
//  - Writes always target the shadow bank as it stands after this cycle's swap (a write in the swap
//    cycle lands in the new shadow, never in the bank being transmitted).
//  - enable dropped mid-frame: next edge enters idle state; pending is kept.
//    Re-enable restarts at pcnt=0.
//  - Async reset mid-frame: outputs return to reset values immediately; banks cleared to 8'hFF.
//  - Outputs are all registered; no combinational path from inputs to outputs.
// TESTING  (C4_HALF=2, CHANNELS=4 -> c4 period 4 clk50, frame 64 c4 periods = 256 clk50)
//  1 Reset, enable=1, no writes -> data_to_dt=1 throughout, stale pulse every 256 clk50,
//    f0 low for 4 clk50 before each frame_start.
//  2 Write ch0..3 = A5,3C,00,FF, commit, run 2 frames -> frame 1 all 1s + swap_done at frame-2 start;
//    frame 2 bits = A5 3C 00 FF MSB first, each bit 8 clk50 wide.
//  3 Write ch1=81 and commit in the exact frame_start cycle -> current frame unchanged;
//    swap_done and 81 in ch1 on the following frame.
//  4 wr_addr=7 (>=CHANNELS) with wr_en -> no bank changes; transmitted data unchanged after commit.
//  5 Drop enable at pcnt=20 -> next cycle c4=0, f0=1, data_to_dt=1; re-enable -> frame_start 1 cycle
//    later, pcnt=0.
//  6 Assert reset_n=0 mid-bit -> c4=0, f0=1, data_to_dt=1 asynchronously; release -> banks read 8'hFF.

Source files
------------

// File: rtl/tdm_frame_tx.sv
// Transmit end of the f0/c4 TDM link.
// Generates the c4 bit clock and the active-low f0 frame pulse from clk50.
// Serialises the active bank of a double-buffered channel table, MSB first, channel 0 first.
// The host writes the shadow bank; a commit swaps the banks at the next frame boundary.
module tdm_frame_tx #(
  parameter int unsigned C4_HALF  = 6,   // clk50 cycles per c4 half-period, min 2
  parameter int unsigned CHANNELS = 32,  // 8-bit channels per frame, min 2
  parameter int unsigned CH_W     = 5    // channel address width, 2**CH_W >= CHANNELS
) (
  input  logic            clk50,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            wr_en,
  input  logic [CH_W-1:0] wr_addr,
  input  logic [7:0]      wr_data,
  input  logic            commit,
  output logic            c4,
  output logic            f0,
  output logic            data_to_dt,
  output logic            frame_start,
  output logic            swap_done,
  output logic            stale
);

  localparam int unsigned Periods = 16 * CHANNELS;  // c4 periods per frame
  localparam int unsigned PcntW   = $clog2(Periods);
  localparam int unsigned DivW    = $clog2(C4_HALF);
  localparam int unsigned IdxW    = $clog2(CHANNELS);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [DivW-1:0]    div_q, div_d;
  logic               ph_q, ph_d;
  logic [PcntW-1:0]   pcnt_q, pcnt_d;
  logic               c4_q, c4_d;
  logic               f0_q, f0_d;
  logic               data_q, data_d;
  logic               frame_start_q, frame_start_d;
  logic               swap_done_q, swap_done_d;
  logic               stale_q, stale_d;
  logic               active_q, active_d;
  logic               pending_q, pending_d;
  logic               enter;     // this edge enters c4 period pcnt_d
  logic               boundary;  // this edge enters period 0
  logic               wr_ok;
  logic [7:0]         bank_q [2][CHANNELS];

  // Next-state for framing counters, line outputs and bank selection.
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    ph_d          = ph_q;
    pcnt_d        = pcnt_q;
    c4_d          = c4_q;
    f0_d          = f0_q;
    data_d        = data_q;
    frame_start_d = 1'b0;
    swap_done_d   = 1'b0;
    stale_d       = 1'b0;
    active_d      = active_q;
    enter         = 1'b0;
    boundary      = 1'b0;

    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StRun;
          div_d   = '0;
          ph_d    = 1'b0;
          pcnt_d  = '0;
          c4_d    = 1'b1;
          enter   = 1'b1;
        end
      end
      StRun: begin
        if (!enable) begin
          state_d = StIdle;
          div_d   = '0;
          ph_d    = 1'b0;
          pcnt_d  = '0;
          c4_d    = 1'b0;
          f0_d    = 1'b1;
          data_d  = 1'b1;
        end else if (div_q == DivW'(C4_HALF - 1)) begin
          div_d = '0;
          if (!ph_q) begin
            c4_d = 1'b0;
            ph_d = 1'b1;
          end else begin
            c4_d   = 1'b1;
            ph_d   = 1'b0;
            pcnt_d = (pcnt_q == PcntW'(Periods - 1)) ? '0 : pcnt_q + 1'b1;
            enter  = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter) begin
      if (pcnt_d == '0) begin
        boundary      = 1'b1;
        f0_d          = 1'b1;
        frame_start_d = 1'b1;
        if (pending_q) begin
          active_d    = ~active_q;
          swap_done_d = 1'b1;
        end else begin
          stale_d = 1'b1;
        end
      end
      if (pcnt_d == PcntW'(Periods - 1)) f0_d = 1'b0;
      // Each data bit spans an even/odd period pair; read from the post-swap active bank.
      if (!pcnt_d[0]) data_d = bank_q[active_d][pcnt_d[PcntW-1:4]][~pcnt_d[3:1]];
    end

    // A commit in the boundary cycle is not seen by that boundary, only the next one.
    if (commit)        pending_d = 1'b1;
    else if (boundary) pending_d = 1'b0;
    else               pending_d = pending_q;

    wr_ok = wr_en && (32'(wr_addr) < CHANNELS);
  end

  // Framing state and registered outputs.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      div_q         <= '0;
      ph_q          <= 1'b0;
      pcnt_q        <= '0;
      c4_q          <= 1'b0;
      f0_q          <= 1'b1;
      data_q        <= 1'b1;
      frame_start_q <= 1'b0;
      swap_done_q   <= 1'b0;
      stale_q       <= 1'b0;
      active_q      <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      ph_q          <= ph_d;
      pcnt_q        <= pcnt_d;
      c4_q          <= c4_d;
      f0_q          <= f0_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
      swap_done_q   <= swap_done_d;
      stale_q       <= stale_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
    end
  end

  // Host writes land in the shadow bank as it stands after this cycle's swap.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < CHANNELS; c++) bank_q[b][c] <= 8'hFF;
      end
    end else if (wr_ok) begin
      bank_q[~active_d][wr_addr[IdxW-1:0]] <= wr_data;
    end
  end

  assign c4          = c4_q;
  assign f0          = f0_q;
  assign data_to_dt  = data_q;
  assign frame_start = frame_start_q;
  assign swap_done   = swap_done_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_tdm_frame_tx.sv
// Bench for tdm_frame_tx with C4_HALF=2, CHANNELS=4: c4 period 4 clk50, frame 256 clk50.
// Expected frames are queued by the stimulus; a negedge monitor pops one per frame_start.
module tb_tdm_frame_tx;

  logic       clk50 = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       commit;
  logic       c4, f0, data_to_dt, frame_start, swap_done, stale;

  typedef struct packed {
    logic        swap;
    logic        stl;
    logic [31:0] data;  // ch0 in [31:24]
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pos     = -1;
  int   n;

  tdm_frame_tx #(
    .C4_HALF (2),
    .CHANNELS(4),
    .CH_W    (3)
  ) dut (
    .clk50      (clk50),
    .reset_n    (reset_n),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .c4         (c4),
    .f0         (f0),
    .data_to_dt (data_to_dt),
    .frame_start(frame_start),
    .swap_done  (swap_done),
    .stale      (stale)
  );

  always #5 clk50 = ~clk50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk50);
    #1;
  endtask

  task automatic wait_fs(output int cnt);
    cnt = 0;
    do begin
      tick(1);
      cnt++;
    end while (!frame_start && cnt < 600);
    chk("wait_frame_start", frame_start, 1);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
  endtask

  task automatic push(input logic s, input logic st, input logic [31:0] d);
    exp_t e;
    e.swap = s; e.stl = st; e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: per frame, check pulses, c4 shape, f0 window and each data bit mid-bit.
  always @(negedge clk50) begin
    if (!reset_n || !enable) begin
      pos = -1;
    end else if (frame_start) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 1, 0);
        cur = '0;
      end else begin
        cur = exp_q.pop_front();
        chk("swap_done", swap_done, cur.swap);
        chk("stale", stale, cur.stl);
      end
      pos = 0;
    end else if (pos >= 0) begin
      pos++;
    end
    if (pos >= 0 && pos < 256) begin
      chk("c4", c4, ((pos % 4) < 2) ? 1 : 0);
      chk("f0", f0, (pos < 252) ? 1 : 0);
      if (pos > 0) chk("pulses_idle", {frame_start, swap_done, stale}, 0);
      if ((pos % 8) == 4) chk("data_bit", data_to_dt, cur.data[31 - pos / 8]);
    end
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
    tick(3);
    chk("rst_c4", c4, 0);
    chk("rst_f0", f0, 1);
    chk("rst_data", data_to_dt, 1);
    chk("rst_pulses", {frame_start, swap_done, stale}, 0);
    reset_n = 1'b1;
    tick(2);
    chk("idle_line", {c4, f0, data_to_dt}, 3'b011);

    // Idle banks: two stale all-ones frames.
    push(0, 1, 32'hFFFF_FFFF);
    push(0, 1, 32'hFFFF_FFFF);
    enable = 1'b1;
    wait_fs(n);
    chk("start_latency", n, 1);
    wait_fs(n);
    chk("frame_len", n, 256);

    // Load shadow and commit during frame 2; frame 3 swaps in.
    wr(0, 8'hA5); wr(1, 8'h3C); wr(2, 8'h00); wr(3, 8'hFF);
    pulse_commit();
    push(1, 0, 32'hA53C_00FF);
    wait_fs(n);

    // Commit and write in the cycle that ends on the boundary: counts for the next frame.
    push(0, 1, 32'hA53C_00FF);
    push(1, 0, 32'hFF81_FFFF);
    tick(255);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h81; commit = 1'b1;
    tick(1);
    wr_en = 1'b0; commit = 1'b0;
    chk("boundary_fs", frame_start, 1);

    // Write in the swap cycle goes to the new shadow; out-of-range write is dropped.
    tick(255);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h11;
    tick(1);
    wr_en = 1'b0;
    wr(7, 8'h00);
    pulse_commit();
    push(1, 0, 32'hA53C_11FF);
    wait_fs(n);

    // Repeated commits give one swap.
    pulse_commit();
    tick(3);
    pulse_commit();
    push(1, 0, 32'hFF81_FFFF);
    wait_fs(n);

    // Drop enable at pcnt=20, then restart.
    tick(80);
    enable = 1'b0;
    tick(1);
    chk("drop_line", {c4, f0, data_to_dt}, 3'b011);
    chk("drop_fs", frame_start, 0);
    push(0, 1, 32'hFF81_FFFF);
    enable = 1'b1;
    tick(1);
    chk("restart_fs", frame_start, 1);
    chk("restart_c4", c4, 1);

    // Pending commit survives a disable.
    pulse_commit();
    tick(30);
    enable = 1'b0;
    tick(5);
    push(1, 0, 32'hA53C_11FF);
    enable = 1'b1;
    tick(1);
    chk("pending_kept_fs", frame_start, 1);

    // Async reset mid-bit while c4=1 and data=0.
    tick(9);
    chk("pre_rst_line", {c4, data_to_dt}, 2'b10);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_c4", c4, 0);
    chk("async_f0", f0, 1);
    chk("async_data", data_to_dt, 1);
    tick(2);
    push(0, 1, 32'hFFFF_FFFF);
    push(1, 0, 32'hFFFF_FFFF);
    reset_n = 1'b1;
    tick(1);
    chk("post_rst_fs", frame_start, 1);
    pulse_commit();
    wait_fs(n);
    tick(255);
    #6;
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
